// File: rtl/mux6_arb_pkg.sv
// mux6_arb_pkg: requester count, select width, idle select code, FSM state type and modulo-6 round-robin step
package mux6_arb_pkg;
  localparam int NUM_REQ = 6;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_IDLE = 3'd7;
  typedef enum logic {ST_IDLE, ST_GRANT} arb_state_t;
  function automatic logic [SEL_W-1:0] next_rr(input logic [SEL_W-1:0] ptr);
    return (ptr >= 3'd5) ? 3'd0 : ptr + 3'd1;
  endfunction
endpackage

// File: rtl/rr_pick6.sv
// rr_pick6: combinational round-robin search; req[5:0], ptr[2:0] in; found, idx[2:0] out (first requester after ptr, idx=7 if none)
module rr_pick6 import mux6_arb_pkg::*; (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);
  logic [SEL_W-1:0] c;
  always_comb begin
    found = 1'b0;
    idx = SEL_IDLE;
    c = next_rr(ptr);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[c]) begin
        found = 1'b1;
        idx = c;
      end
      c = next_rr(c);
    end
  end
endmodule

// File: rtl/mux6_rr_arbiter.sv
// mux6_rr_arbiter: burst-granular round-robin arbiter over six req/req_last/data ports to one out_valid/out_ready/out_data sink, with ack, sel, busy; MUX6_ARB_BURST_LIMIT_EN caps a grant at MAX_BURST beats
module mux6_rr_arbiter import mux6_arb_pkg::*; #(
  parameter int DATA_W = 4,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_last,
  input  logic [DATA_W-1:0]  data0,
  input  logic [DATA_W-1:0]  data1,
  input  logic [DATA_W-1:0]  data2,
  input  logic [DATA_W-1:0]  data3,
  input  logic [DATA_W-1:0]  data4,
  input  logic [DATA_W-1:0]  data5,
  output logic [NUM_REQ-1:0] ack,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [SEL_W-1:0]   sel,
  output logic               busy
);
  arb_state_t state;
  logic [SEL_W-1:0] ptr, idx;
  logic found, accept, done;
  logic [7:0] req_x, last_x;
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
    $error("MAX_BURST out of range 1..15");
  end
  // widened so that indexing with the idle code 7 reads a zero
  assign req_x = {2'b00, req};
  assign last_x = {2'b00, req_last};
  rr_pick6 u_pick (.req(req), .ptr(ptr), .found(found), .idx(idx));
  assign busy = state == ST_GRANT;
  assign out_valid = busy && req_x[sel];
  assign accept = out_valid && out_ready;
  assign ack = accept ? (NUM_REQ'(1) << sel) : '0;
  assign out_data = sel == 3'd0 ? data0 :
                    sel == 3'd1 ? data1 :
                    sel == 3'd2 ? data2 :
                    sel == 3'd3 ? data3 :
                    sel == 3'd4 ? data4 :
                    sel == 3'd5 ? data5 : '0;
`ifdef MUX6_ARB_BURST_LIMIT_EN
  logic [3:0] beat_cnt;
  // the MAX_BURST-th beat of a grant ends it just like req_last
  assign done = last_x[sel] || beat_cnt == 4'(MAX_BURST - 1);
  always_ff @(posedge clk)
    if (reset || !busy) beat_cnt <= '0;
    else if (accept) beat_cnt <= done ? 4'd0 : beat_cnt + 4'd1;
`else
  assign done = last_x[sel];
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= ST_IDLE;
      sel <= SEL_IDLE;
      ptr <= 3'd5;
    end else if (state == ST_IDLE) begin
      if (found) begin
        state <= ST_GRANT;
        sel <= idx;
      end
    end else if (!req_x[sel] || (accept && done)) begin
      state <= ST_IDLE;
      ptr <= sel;
      sel <= SEL_IDLE;
    end
endmodule

// File: tb/tb_mux6_rr_arbiter.sv
// tb_mux6_rr_arbiter: scenario tasks with a scoreboard of expected (port, data) beats checked on every accepted beat
module tb_mux6_rr_arbiter;
`ifdef MUX6_ARB_BURST_LIMIT_EN
  localparam int MB = 2;
`else
  localparam int MB = 4;
`endif
  logic clk = 1'b0, reset = 1'b1, out_ready = 1'b0;
  logic [5:0] req = '0, req_last = '0, ack, acc = '0, sb_ack;
  logic [3:0] d [6];
  logic out_valid, busy;
  logic [3:0] out_data;
  logic [2:0] sel;
  logic [6:0] exp_q [$];
  logic [6:0] sb_e;
  logic [4:0] pb [6][16];
  int ph [6], pt [6];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  mux6_rr_arbiter #(.DATA_W(4), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .req_last(req_last),
    .data0(d[0]), .data1(d[1]), .data2(d[2]), .data3(d[3]), .data4(d[4]), .data5(d[5]),
    .ack(ack), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sel(sel), .busy(busy)
  );

  always @(negedge clk) begin
    acc = '0;
    if (out_valid === 1'b1 && out_ready) begin
      acc = ack;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_extra: ack=%b sel=%0d data=%h, no beat expected", ack, sel, out_data);
      end else begin
        sb_e = exp_q.pop_front();
        sb_ack = 6'b1 << sb_e[6:4];
        if (ack !== sb_ack || sel !== sb_e[6:4] || out_data !== sb_e[3:0]) begin
          n_bad++;
          $display("FAIL sb_beat: ack=%b sel=%0d data=%h, required ack=%b sel=%0d data=%h",
                   ack, sel, out_data, sb_ack, sb_e[6:4], sb_e[3:0]);
        end
      end
    end
  end

  task automatic refresh();
    for (int i = 0; i < 6; i++) begin
      req[i] = ph[i] != pt[i];
      req_last[i] = req[i] && pb[i][ph[i]][4];
      d[i] = req[i] ? pb[i][ph[i]][3:0] : 4'h0;
    end
  endtask

  task automatic add(input int p, input logic [3:0] dat, input logic last);
    pb[p][pt[p]] = {last, dat};
    pt[p]++;
  endtask

  task automatic expect_beat(input int p, input logic [3:0] dat);
    exp_q.push_back({3'(p), dat});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) if (acc[i] && ph[i] != pt[i]) ph[i]++;
    refresh();
  endtask

  task automatic start_test();
    for (int i = 0; i < 6; i++) begin
      ph[i] = 0;
      pt[i] = 0;
    end
    exp_q.delete();
    out_ready = 1'b1;
    reset = 1'b1;
    refresh();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    start_test();
    @(negedge clk);
    n_cmp++;
    if (sel !== 3'd7 || out_valid !== 1'b0 || busy !== 1'b0 || ack !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_state: sel=%0d valid=%b busy=%b ack=%b, required 7 0 0 000000", sel, out_valid, busy, ack);
    end
    add(2, 4'h3, 1'b1);
    reset = 1'b1;
    refresh();
    step();
    @(negedge clk);
    n_cmp++;
    if (sel !== 3'd7 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold: sel=%0d busy=%b valid=%b, required 7 0 0", sel, busy, out_valid);
    end
    reset = 1'b0;
    expect_beat(2, 4'h3);
    drain(6);
  endtask

  task automatic test_two_ports();
    int es [5] = '{7, 0, 7, 5, 7};
    int ea [5] = '{0, 1, 0, 32, 0};
    start_test();
    add(0, 4'h1, 1'b1);
    add(5, 4'h6, 1'b1);
    expect_beat(0, 4'h1);
    expect_beat(5, 4'h6);
    refresh();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (sel !== 3'(es[k]) || ack !== 6'(ea[k])) begin
        n_bad++;
        $display("FAIL two_ports[%0d]: sel=%0d ack=%b, required sel=%0d ack=%b", k, sel, ack, es[k], 6'(ea[k]));
      end
      step();
    end
    drain(2);
  endtask

  task automatic test_wrap();
    int order [7] = '{0, 1, 2, 3, 4, 5, 0};
    start_test();
    for (int i = 0; i < 6; i++) add(i, 4'(i + 1), 1'b1);
    add(0, 4'h8, 1'b1);
    for (int i = 0; i < 6; i++) expect_beat(i, 4'(i + 1));
    expect_beat(0, 4'h8);
    refresh();
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'(k % 2) || sel !== ((k % 2) ? 3'(order[k / 2]) : 3'd7)) begin
        n_bad++;
        $display("FAIL wrap[%0d]: valid=%b sel=%0d, required valid=%0d sel=%0d", k, out_valid, sel, k % 2,
                 (k % 2) ? order[k / 2] : 7);
      end
      step();
    end
    drain(2);
  endtask

  task automatic test_back_to_back();
    int ev [7] = '{0, 1, 1, 1, 0, 1, 0};
    int es [7] = '{7, 2, 2, 2, 7, 3, 7};
    int eo [7] = '{0, 10, 11, 12, 0, 5, 0};
    start_test();
    add(2, 4'hA, 1'b0);
    add(2, 4'hB, 1'b0);
    add(2, 4'hC, 1'b1);
    add(3, 4'h5, 1'b1);
    expect_beat(2, 4'hA);
    expect_beat(2, 4'hB);
    expect_beat(2, 4'hC);
    expect_beat(3, 4'h5);
    refresh();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'(ev[k]) || sel !== 3'(es[k]) || out_data !== 4'(eo[k])) begin
        n_bad++;
        $display("FAIL burst[%0d]: valid=%b sel=%0d data=%h, required %0d %0d %h", k, out_valid, sel, out_data,
                 ev[k], es[k], 4'(eo[k]));
      end
      step();
    end
    drain(2);
  endtask

  task automatic test_backpressure();
    int ev [7] = '{0, 1, 1, 1, 1, 1, 0};
    int es [7] = '{7, 1, 1, 1, 1, 1, 7};
    int ea [7] = '{0, 0, 0, 0, 0, 2, 0};
    start_test();
    out_ready = 1'b0;
    add(1, 4'h7, 1'b1);
    expect_beat(1, 4'h7);
    refresh();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'(ev[k]) || sel !== 3'(es[k]) || ack !== 6'(ea[k])) begin
        n_bad++;
        $display("FAIL backpressure[%0d]: valid=%b sel=%0d ack=%b, required %0d %0d %b", k, out_valid, sel, ack,
                 ev[k], es[k], 6'(ea[k]));
      end
      step();
      if (k == 4) out_ready = 1'b1;
    end
    drain(2);
  endtask

  task automatic test_abort();
    int ev [7] = '{0, 1, 0, 0, 1, 0, 1};
    int es [7] = '{7, 4, 4, 7, 5, 7, 0};
    int ea [7] = '{0, 16, 0, 0, 32, 0, 1};
    start_test();
    add(4, 4'h1, 1'b0);
    add(4, 4'h2, 1'b0);
    add(4, 4'h3, 1'b1);
    expect_beat(4, 4'h1);
    expect_beat(5, 4'h6);
    expect_beat(0, 4'h9);
    refresh();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'(ev[k]) || sel !== 3'(es[k]) || ack !== 6'(ea[k])) begin
        n_bad++;
        $display("FAIL abort[%0d]: valid=%b sel=%0d ack=%b, required %0d %0d %b", k, out_valid, sel, ack,
                 ev[k], es[k], 6'(ea[k]));
      end
      step();
      if (k == 1) begin
        ph[4] = pt[4];
        add(5, 4'h6, 1'b1);
        add(0, 4'h9, 1'b1);
        refresh();
      end
    end
    drain(2);
  endtask

  task automatic test_reset_mid_burst();
    start_test();
    add(3, 4'h1, 1'b0);
    add(3, 4'h2, 1'b0);
    add(3, 4'h3, 1'b1);
    expect_beat(3, 4'h1);
    refresh();
    @(negedge clk);
    step();
    @(negedge clk);
    n_cmp++;
    if (sel !== 3'd3 || ack !== 6'b001000) begin
      n_bad++;
      $display("FAIL mid_first: sel=%0d ack=%b, required 3 001000", sel, ack);
    end
    step();
    reset = 1'b1;
    out_ready = 1'b0;
    add(0, 4'hE, 1'b1);
    refresh();
    @(negedge clk);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (sel !== 3'd7 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: sel=%0d valid=%b busy=%b, required 7 0 0", sel, out_valid, busy);
    end
    expect_beat(0, 4'hE);
    expect_beat(3, 4'h2);
    expect_beat(3, 4'h3);
    step();
    @(negedge clk);
    n_cmp++;
    if (sel !== 3'd0) begin
      n_bad++;
      $display("FAIL mid_winner: sel=%0d, required 0", sel);
    end
    drain(12);
  endtask

`ifdef MUX6_ARB_BURST_LIMIT_EN
  task automatic test_burst_limit();
    int es [5] = '{7, 1, 1, 7, 2};
    start_test();
    for (int i = 1; i <= 6; i++) add(1, 4'(i), i == 6);
    add(2, 4'h9, 1'b1);
    expect_beat(1, 4'h1);
    expect_beat(1, 4'h2);
    expect_beat(2, 4'h9);
    for (int i = 3; i <= 6; i++) expect_beat(1, 4'(i));
    refresh();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (sel !== 3'(es[k])) begin
        n_bad++;
        $display("FAIL limit[%0d]: sel=%0d, required %0d", k, sel, es[k]);
      end
      step();
    end
    drain(20);
  endtask
`endif

  initial begin
    for (int i = 0; i < 6; i++) begin
      d[i] = 4'h0;
      ph[i] = 0;
      pt[i] = 0;
    end
    test_reset();
    test_two_ports();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_reset_mid_burst();
`ifdef MUX6_ARB_BURST_LIMIT_EN
    test_burst_limit();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
